// File: rtl/stream_demux_if.sv
// Valid/ready bundle between a single producer and the demux's per-channel output slots.
// The producer side drives master; the demux is attached through slave.
interface stream_demux_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3
) ();

    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/stream_demux.sv
// 1-to-CHANNELS valid/ready demux with one registered slot per channel, broadcast mode,
// and a saturating counter of transfers dropped for an out-of-range select.
module stream_demux #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_demux_if.slave    bus,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned SEL_N  = 1 << SEL_W;
    localparam int unsigned DATA_W = CHANNELS * WIDTH;

    logic [CHANNELS-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [CNT_W-1:0]    drop_q,  drop_d;

    logic [CHANNELS-1:0] free_c;
    logic [SEL_N-1:0]    free_pad_c;
    logic [SEL_N-1:0]    sel_dec_c;
    logic [CHANNELS-1:0] load_c;
    logic                in_range_c;
    logic                in_ready_c;
    logic                accept_c;
    logic                drop_c;

    // Slot readiness and routing; in_ready is deliberately independent of in_valid.
    always_comb begin
        free_c     = ~valid_q | bus.out_ready;
        free_pad_c = SEL_N'(free_c);
        in_range_c = (32'(bus.in_sel) < CHANNELS);
        sel_dec_c  = SEL_N'(1) << bus.in_sel;

        in_ready_c = 1'b1;
        if (bus.in_bcast) begin
            in_ready_c = &free_c;
        end else if (in_range_c) begin
            in_ready_c = free_pad_c[bus.in_sel];
        end

        accept_c = bus.in_valid & in_ready_c;
        load_c   = '0;
        drop_c   = 1'b0;
        if (accept_c) begin
            if (bus.in_bcast) begin
                load_c = '1;
            end else if (in_range_c) begin
                load_c = CHANNELS'(sel_dec_c);
            end else begin
                drop_c = 1'b1;
            end
        end
    end

    // Next-state: a load wins over a same-cycle drain so a slot streams without bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = drop_q;

        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (load_c[k]) begin
                valid_d[k]                = 1'b1;
                data_d[k*WIDTH +: WIDTH]  = bus.in_data;
            end else if (valid_q[k] && bus.out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end

        if (drop_c && !(&drop_q)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign drop_count    = drop_q;

endmodule
